// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; at least one bit so N = 2 still has a counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/done request bus between a requester and the serial subtractor.
interface serial_sub_ctrl_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_sub_ctrl_fullsubtractor.sv
// One-bit full subtractor cell: diff = a - b - cin, brf = borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic brf
);
  assign diff = a ^ b ^ cin;
  assign brf  = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor: one full-subtractor cell reused LSB first,
// borrow carried between cycles; returns diff, borrow-out and signed overflow.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int            CW     = cnt_width(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] PENULT = CW'(N - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic          brw_q, brw_d, bmsb_q, bmsb_d, bout_q, bout_d, ovf_q, ovf_d;
  logic          cell_diff, cell_brf, accept, busy, done;

  fullsubtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (brw_q),
    .diff (cell_diff),
    .brf  (cell_brf)
  );

  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? RUN : IDLE;
      RUN:        if (cnt_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    brw_d  = brw_q;
    bmsb_d = bmsb_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.b;
      brw_d = bus.bin;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {cell_diff, res_q[N-1:1]};
      brw_d = cell_brf;
      // The borrow leaving bit N-2 is the borrow into the MSB.
      if (cnt_q == PENULT) bmsb_d = cell_brf;
      if (cnt_q == LAST) begin
        diff_d = {cell_diff, res_q[N-1:1]};
        bout_d = cell_brf;
        ovf_d  = bmsb_q ^ cell_brf;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      bmsb_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      brw_q  <= brw_d;
      bmsb_q <= bmsb_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at N = 8 and an exhaustive N = 3 instance.
module tb_serial_sub_ctrl;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscomp = 0;
  exp_t q8[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.N(8)) i8 ();
  serial_sub_ctrl_if #(.N(3)) i3 ();

  serial_sub_ctrl #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_sub_ctrl #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));

  function automatic exp_t model(input int n, input int a, input int b, input int bin);
    exp_t m;
    int full, half, u, sa, sb, s;
    full = 1 << n;
    half = full >> 1;
    u = a - b - bin;
    m.diff = 8'((u + 2 * full) % full);
    m.bout = (u < 0);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    s  = sa - sb - bin;
    m.ovf = (s < -half) || (s >= half);
    return m;
  endfunction

  // Called right after a negedge; returns at the next negedge with start low.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.bin = bin;
    q8.push_back(model(8, int'(a), int'(b), int'(bin)));
    @(negedge clk);
    i8.start = 1'b0;
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic bin);
    i3.start = 1'b1; i3.a = a; i3.b = b; i3.bin = bin;
    q3.push_back(model(3, int'(a), int'(b), int'(bin)));
    @(negedge clk);
    i3.start = 1'b0;
  endtask

  task automatic collect8(input string name, input int lat0, output int lat);
    exp_t e;
    lat = lat0;
    while (i8.done !== 1'b1 && lat < lat0 + 40) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (i8.done !== 1'b1) begin
      miscomp++; lat = -1;
      $display("FAIL %s timeout: done got %b want 1", name, i8.done);
    end else if (q8.size() == 0) begin
      miscomp++;
      $display("FAIL %s: done got 1 want no pending result", name);
    end else begin
      e = q8.pop_front();
      if (i8.diff !== e.diff) begin miscomp++; $display("FAIL %s diff: got %h want %h", name, i8.diff, e.diff); end
      vectors++;
      if (i8.bout !== e.bout) begin miscomp++; $display("FAIL %s bout: got %b want %b", name, i8.bout, e.bout); end
      vectors++;
      if (i8.ovf !== e.ovf) begin miscomp++; $display("FAIL %s ovf: got %b want %b", name, i8.ovf, e.ovf); end
      vectors++;
      if (i8.busy !== 1'b0) begin miscomp++; $display("FAIL %s busy_at_done: got %b want 0", name, i8.busy); end
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int want);
    vectors++;
    if (lat !== want) begin
      miscomp++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, want);
    end
  endtask

  task automatic test_reset();
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
    i3.start = 1'b0; i3.a = '0; i3.b = '0; i3.bin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({i8.busy, i8.done, i8.diff, i8.bout, i8.ovf} !== 12'h000) begin
      miscomp++;
      $display("FAIL reset8: got busy%b done%b diff%h bout%b ovf%b want all 0",
               i8.busy, i8.done, i8.diff, i8.bout, i8.ovf);
    end
    vectors++;
    if ({i3.busy, i3.done, i3.diff, i3.bout, i3.ovf} !== 7'h00) begin
      miscomp++;
      $display("FAIL reset3: got busy%b done%b diff%h bout%b ovf%b want all 0",
               i3.busy, i3.done, i3.diff, i3.bout, i3.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (i8.busy !== 1'b0 || i8.done !== 1'b0) begin
      miscomp++;
      $display("FAIL idle_after_reset: got busy%b done%b want 00", i8.busy, i8.done);
    end
  endtask

  task automatic test_basic();
    int lat;
    issue8(8'h05, 8'h03, 1'b0);
    vectors++;
    if (i8.busy !== 1'b1) begin miscomp++; $display("FAIL busy_in_run: got %b want 1", i8.busy); end
    collect8("small_pos", 1, lat);
    check_lat("small_pos", lat, 9);
    issue8(8'h03, 8'h05, 1'b0); collect8("underflow", 1, lat);
    issue8(8'h00, 8'h00, 1'b1); collect8("borrow_in", 1, lat);
    issue8(8'h80, 8'h01, 1'b0); collect8("ovf_neg", 1, lat);
    issue8(8'h7F, 8'hFF, 1'b0); collect8("ovf_pos", 1, lat);
    check_lat("ovf_pos", lat, 9);
  endtask

  task automatic test_start_ignored();
    int lat;
    issue8(8'hA5, 8'h3C, 1'b1);
    @(negedge clk);
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'h11; i8.bin = 1'b0;
    @(negedge clk);
    i8.start = 1'b0;
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h22;
    @(negedge clk);
    i8.start = 1'b0;
    collect8("start_ignored", 6, lat);
    check_lat("start_ignored", lat, 9);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] av [3] = '{8'h10, 8'h42, 8'hC8};
    logic [7:0] bv [3] = '{8'h20, 8'h41, 8'h37};
    logic       cv [3] = '{1'b0, 1'b1, 1'b1};
    i8.start = 1'b1; i8.a = av[0]; i8.b = bv[0]; i8.bin = cv[0];
    q8.push_back(model(8, int'(av[0]), int'(bv[0]), int'(cv[0])));
    @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      i8.a = av[i]; i8.b = bv[i]; i8.bin = cv[i];
      q8.push_back(model(8, int'(av[i]), int'(bv[i]), int'(cv[i])));
      collect8("held_start", 1, lat);
      check_lat("held_start", lat, 9);
      @(negedge clk);
    end
    i8.start = 1'b0;
    collect8("held_start_last", 1, lat);
    check_lat("held_start_last", lat, 9);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit seen;
    issue8(8'h5A, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({i8.busy, i8.done, i8.diff, i8.bout, i8.ovf} !== 12'h000) begin
      miscomp++;
      $display("FAIL reset_mid_run: got busy%b done%b diff%h bout%b ovf%b want all 0",
               i8.busy, i8.done, i8.diff, i8.bout, i8.ovf);
    end
    void'(q8.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i8.done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscomp++; $display("FAIL no_done_after_abort: got %b want 0", seen); end
    issue8(8'h5A, 8'h0F, 1'b0);
    collect8("after_abort", 1, lat);
    check_lat("after_abort", lat, 9);
  endtask

  task automatic test_exhaustive_n3();
    exp_t e;
    int   lat;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue3(3'(a), 3'(b), 1'(c));
          lat = 1;
          while (i3.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
          end
          vectors++;
          if (i3.done !== 1'b1 || q3.size() == 0) begin
            miscomp++;
            $display("FAIL n3 timeout a=%0d b=%0d bin=%0d: done got %b want 1", a, b, c, i3.done);
          end else begin
            e = q3.pop_front();
            if ({i3.bout, i3.diff} !== {e.bout, e.diff[2:0]}) begin
              miscomp++;
              $display("FAIL n3 a=%0d b=%0d bin=%0d: {bout,diff} got %h want %h",
                       a, b, c, {i3.bout, i3.diff}, {e.bout, e.diff[2:0]});
            end
            vectors++;
            if (i3.ovf !== e.ovf) begin
              miscomp++;
              $display("FAIL n3 ovf a=%0d b=%0d bin=%0d: got %b want %b", a, b, c, i3.ovf, e.ovf);
            end
            vectors++;
            if (lat !== 4) begin
              miscomp++;
              $display("FAIL n3 latency: got %0d want 4", lat);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_n3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
